ps_stage_sync: RTL and testbench
================================

// Module: ps_stage_sync
// PURPOSE
//  Clocked, parametrised program-storage stage for the data-driven pipeline. Takes a token
//  packet, looks up its instruction by dest in a writable program memory, and emits one
//  packet (two when CPY fan-out is set), or deletes the token (DEL) on an invalid entry.
//  Sits between the matching (MM) side and the FP stage. Uses valid/ready handshakes.
// PARAMETERS
//  COLOR_W  3   color field width
//  GEN_W    8   generation field width
//  DEST_W   7   dest field width; program depth = 2**DEST_W
//  OPC_W    6   opcode width
//  DATA_W   32  data width
// PORTS
//  CLK         in   1   clock; all logic on rising edge
//  MR_N        in   1   master reset, synchronous, active-low
//  in_valid    in   1   PACKET_IN valid
//  in_ready    out  1   stage can accept PACKET_IN
//  PACKET_IN   in   COLOR_W+GEN_W+DEST_W+2+DATA_W   {color,gen,dest,C,Z,data}
//  out_valid   out  1   PACKET_OUT valid
//  out_ready   in   1   downstream accepts PACKET_OUT
//  PACKET_OUT  out  COLOR_W+GEN_W+DEST_W+6+OPC_W+DATA_W  {color,gen,dest,LR,BR,MF,CPY,OPC,C,Z,data}
//  DEL         out  1   one-cycle pulse: token deleted (invalid program entry)
//  prog_we     in   1   program write strobe
//  prog_addr   in   DEST_W   program write address
//  prog_wdata  in   2*DEST_W+OPC_W+6   entry {valid,ndest,LR,BR,MF,CPY,OPC,ndest2,LR2}
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset (MR_N=0 at edge): state=IDLE, out_valid=0, DEL=0, PACKET_OUT=0, all entry valid
//    bits=0 (valid bits in flops; rest of entry in RAM, not reset). Reset wins over all.
//  - States IDLE, LOOKUP, OUT1, OUT2.
//  - IDLE: in_ready = ~prog_we. prog_we writes entry at prog_addr (write has priority; no
//    input accepted that cycle). in_valid&in_ready: capture packet, read entry[dest] -> LOOKUP.
//  - prog_we outside IDLE: still written; ignored by the token already in LOOKUP/OUT*
//    (entry was latched at LOOKUP).
//  - LOOKUP (1 cycle, sync RAM read): entry.valid=0 -> DEL=1 next cycle, token dropped,
//    -> IDLE. entry.valid=1 -> PACKET_OUT = {color,gen,ndest,LR,BR,MF,CPY,OPC,C,Z,data},
//    out_valid=1 -> OUT1.
//  - OUT1: hold PACKET_OUT stable while out_valid&~out_ready. On handshake: CPY=0 -> IDLE,
//    out_valid=0; CPY=1 -> PACKET_OUT dest=ndest2, LR=LR2, all else identical -> OUT2.
//  - OUT2: hold until handshake -> IDLE, out_valid=0.
//  - Latency: input handshake to out_valid = 2 cycles. Peak rate: 1 token / 3 cycles (no CPY).
//  - in_ready=0 in every state except IDLE; no packet lost or duplicated under any
//    out_ready pattern. CPY copy pair always back-to-back, never interleaved with other tokens.
//  - color, gen, C, Z, data pass unmodified; no arithmetic on fields.
//  - dest wrap: dest=2**DEST_W-1 is a normal address; no out-of-range case exists.
//  - Mid-operation reset: in-flight token discarded, no DEL, no out pulse; program
//    entries become invalid until rewritten.
// TESTING
//  1 Reset then write entry[1]={v=1,ndest=5,CPY=0,OPC=3}; send dest=1,data=0xA5A5_0001
//    -> 2 cycles later one packet dest=5,OPC=3,data=0xA5A5_0001; busy drops after handshake.
//  2 No write to entry[2]; send dest=2 -> DEL=1 exactly one cycle, out_valid stays 0.
//  3 entry[3]={v=1,ndest=10,LR=0,CPY=1,ndest2=11,LR2=1}; send dest=3 -> two packets in
//    order dest=10/LR=0 then dest=11/LR=1, identical color/gen/data.
//  4 Test 1 with out_ready=0 for 5 cycles -> PACKET_OUT stable, in_ready=0, then one packet.
//  5 prog_we=1 and in_valid=1 same cycle in IDLE -> in_ready=0, write done, token next cycle.
//  6 MR_N=0 while in OUT2 -> out_valid=0 next cycle, no DEL; resend dest=3 -> DEL=1.

Source files
------------

// File: rtl/ps_stage_sync_if.sv
// Handshake and program-write bundle for the program-storage stage.
// slave = the stage itself, master = the side driving tokens and program writes.
interface ps_stage_sync_if #(
  parameter int COLOR_W = 3,
  parameter int GEN_W   = 8,
  parameter int DEST_W  = 7,
  parameter int OPC_W   = 6,
  parameter int DATA_W  = 32
);
  localparam int IN_W  = COLOR_W + GEN_W + DEST_W + 2 + DATA_W;
  localparam int OUT_W = COLOR_W + GEN_W + DEST_W + 6 + OPC_W + DATA_W;
  localparam int ENT_W = 2 * DEST_W + OPC_W + 6;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   PACKET_IN;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  PACKET_OUT;
  logic              DEL;
  logic              prog_we;
  logic [DEST_W-1:0] prog_addr;
  logic [ENT_W-1:0]  prog_wdata;
  logic              busy;

  modport slave (
    input  in_valid, PACKET_IN, out_ready,
    input  prog_we, prog_addr, prog_wdata,
    output in_ready, out_valid, PACKET_OUT,
    output DEL, busy
  );

  modport master (
    output in_valid, PACKET_IN, out_ready,
    output prog_we, prog_addr, prog_wdata,
    input  in_ready, out_valid, PACKET_OUT,
    input  DEL, busy
  );
endinterface

// File: rtl/ps_stage_sync.sv
// Program-storage stage: looks up a token's instruction by dest and emits
// one packet (two with CPY fan-out) or deletes the token on an invalid entry.
module ps_stage_sync #(
  parameter int COLOR_W = 3,
  parameter int GEN_W   = 8,
  parameter int DEST_W  = 7,
  parameter int OPC_W   = 6,
  parameter int DATA_W  = 32
) (
  input logic           CLK,
  input logic           MR_N,
  ps_stage_sync_if.slave bus
);
  localparam int DEPTH = 2 ** DEST_W;
  localparam int OUT_W = COLOR_W + GEN_W + DEST_W + 6 + OPC_W + DATA_W;
  localparam int ENT_W = 2 * DEST_W + OPC_W + 6;
  localparam int RAM_W = ENT_W - 1;
  localparam int HI_W  = COLOR_W + GEN_W;
  localparam int LO_W  = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    OUT1,
    OUT2
  } state_t;

  state_t            state;
  logic [RAM_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [RAM_W-1:0]  ent;
  logic              ent_v;
  logic [HI_W-1:0]   hi;
  logic [LO_W-1:0]   lo;
  logic              out_valid;
  logic              del;
  logic [OUT_W-1:0]  pkt_out;

  logic              accept;
  logic [DEST_W-1:0] in_dest;
  logic [DEST_W-1:0] nd;
  logic [DEST_W-1:0] nd2;
  logic [OPC_W-1:0]  opc;
  logic              lr;
  logic              br;
  logic              mf;
  logic              cpy;
  logic              lr2;
  logic [OUT_W-1:0]  pkt1;
  logic [OUT_W-1:0]  pkt2;

  assign in_dest = bus.PACKET_IN[DATA_W+2 +: DEST_W];
  assign accept  = bus.in_valid & bus.in_ready;

  assign {nd, lr, br, mf, cpy, opc, nd2, lr2} = ent;
  assign pkt1 = {hi, nd, lr, br, mf, cpy, opc, lo};
  assign pkt2 = {hi, nd2, lr2, br, mf, cpy, opc, lo};

  assign bus.in_ready   = (state == IDLE) & ~bus.prog_we;
  assign bus.out_valid  = out_valid;
  assign bus.PACKET_OUT = pkt_out;
  assign bus.DEL        = del;
  assign bus.busy       = (state != IDLE);

  // Entry body lives in RAM; only the valid bits need a reset.
  always_ff @(posedge CLK) begin
    if (bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_wdata[RAM_W-1:0];
    if (accept)
      ent <= mem[in_dest];
  end

  always_ff @(posedge CLK) begin
    if (!MR_N) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      del       <= 1'b0;
      pkt_out   <= '0;
      vld       <= '0;
      ent_v     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      del <= 1'b0;
      if (bus.prog_we)
        vld[bus.prog_addr] <= bus.prog_wdata[ENT_W-1];
      case (state)
        IDLE: begin
          if (accept) begin
            hi    <= bus.PACKET_IN[LO_W+DEST_W +: HI_W];
            lo    <= bus.PACKET_IN[LO_W-1:0];
            ent_v <= vld[in_dest];
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!ent_v) begin
            del   <= 1'b1;
            state <= IDLE;
          end else begin
            pkt_out   <= pkt1;
            out_valid <= 1'b1;
            state     <= OUT1;
          end
        end
        OUT1: begin
          if (bus.out_ready) begin
            if (cpy) begin
              pkt_out <= pkt2;
              state   <= OUT2;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        OUT2: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps_stage_sync.sv
// Randomised bench for ps_stage_sync against a program-table model
// that maps each token to its list of expected output packets.
module tb_ps_stage_sync;
  localparam int COLOR_W = 3;
  localparam int GEN_W   = 8;
  localparam int DEST_W  = 7;
  localparam int OPC_W   = 6;
  localparam int DATA_W  = 32;
  localparam int IN_W  = COLOR_W + GEN_W + DEST_W + 2 + DATA_W;
  localparam int OUT_W = COLOR_W + GEN_W + DEST_W + 6 + OPC_W + DATA_W;
  localparam int ENT_W = 2 * DEST_W + OPC_W + 6;

  typedef struct {
    bit              v;
    bit [DEST_W-1:0] nd;
    bit              lr, br, mf, cpy;
    bit [OPC_W-1:0]  opc;
    bit [DEST_W-1:0] nd2;
    bit              lr2;
  } ent_t;

  typedef logic [OUT_W-1:0] pkt_q_t [$];

  logic clk = 1'b0;
  logic mr_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  ent_t prog [2**DEST_W];

  ps_stage_sync_if bus ();

  ps_stage_sync dut (
    .CLK  (clk),
    .MR_N (mr_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [IN_W-1:0] mktok(
    input logic [COLOR_W-1:0] color, input logic [GEN_W-1:0] gen,
    input logic [DEST_W-1:0] dest, input logic c, input logic z,
    input logic [DATA_W-1:0] data);
    return {color, gen, dest, c, z, data};
  endfunction

  // Expected output of a token: nothing (deleted), or one/two packets.
  function automatic void model(input logic [IN_W-1:0] tok,
                                output pkt_q_t q, output int del);
    logic [COLOR_W-1:0] color;
    logic [GEN_W-1:0]   gen;
    logic [DEST_W-1:0]  dest;
    logic               c, z;
    logic [DATA_W-1:0]  data;
    ent_t e;
    {color, gen, dest, c, z, data} = tok;
    e = prog[dest];
    q = {};
    del = e.v ? 0 : 1;
    if (e.v) begin
      q.push_back({color, gen, e.nd, e.lr, e.br, e.mf, e.cpy, e.opc,
                   c, z, data});
      if (e.cpy)
        q.push_back({color, gen, e.nd2, e.lr2, e.br, e.mf, e.cpy, e.opc,
                     c, z, data});
    end
  endfunction

  task automatic wr_entry(input logic [DEST_W-1:0] a, input ent_t e);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = a;
    bus.prog_wdata = {e.v, e.nd, e.lr, e.br, e.mf, e.cpy, e.opc,
                      e.nd2, e.lr2};
    @(negedge clk);
    bus.prog_we = 1'b0;
    prog[a] = e;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2**DEST_W; i++) prog[i].v = 1'b0;
  endtask

  // Sends one token, then watches outputs until the stage is idle again.
  task automatic xfer(input logic [IN_W-1:0] tok, input int stall,
                      input int hold, output pkt_q_t got,
                      output int ndel, output int lat,
                      output int done, output int viol);
    logic [OUT_W-1:0] prev;
    bit pend;
    int w;
    got = {}; ndel = 0; lat = -1; done = -1; viol = 0; pend = 0;
    prev = '0;
    bus.in_valid  = 1'b1;
    bus.PACKET_IN = tok;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int n = 1; n < 80; n++) begin
      if (bus.DEL) ndel++;
      if (bus.out_valid && lat < 0) lat = n;
      if (bus.busy && bus.in_ready) viol++;
      if (bus.out_valid && pend && bus.PACKET_OUT !== prev) viol++;
      if (lat >= 0 && n - lat < hold) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(99) >= stall);
      pend = 0;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.PACKET_OUT);
      else if (bus.out_valid) begin pend = 1; prev = bus.PACKET_OUT; end
      if (n >= 3 && !bus.busy && !bus.out_valid) begin
        done = n;
        break;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    mr_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.DEL !== 1'b0) begin n_fail++;
      $display("FAIL reset_del got %b want 0", bus.DEL); end
    n_checks++;
    if (bus.PACKET_OUT !== '0) begin n_fail++;
      $display("FAIL reset_pkt got %h want 0", bus.PACKET_OUT); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", bus.busy); end
    mr_n = 1'b1;
    clear_model();
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single(input int hold, input string nm);
    ent_t e;
    pkt_q_t got, exp;
    int ndel, edel, lat, done, viol;
    logic [IN_W-1:0] tok;
    e = '{v:1, nd:5, lr:0, br:0, mf:0, cpy:0, opc:3, nd2:0, lr2:0};
    wr_entry(1, e);
    tok = mktok(3'd2, 8'h17, 7'd1, 1'b1, 1'b0, 32'hA5A5_0001);
    model(tok, exp, edel);
    xfer(tok, 0, hold, got, ndel, lat, done, viol);
    n_checks++;
    if (got.size() !== 1 || got[0] !== exp[0]) begin n_fail++;
      $display("FAIL %s_pkt got n=%0d %h want %h", nm, got.size(),
               got.size() ? got[0] : '0, exp[0]); end
    n_checks++;
    if (lat !== 2) begin n_fail++;
      $display("FAIL %s_latency got %0d want 2", nm, lat); end
    n_checks++;
    if (done !== 3 + hold) begin n_fail++;
      $display("FAIL %s_busy_drop got %0d want %0d", nm, done, 3 + hold); end
    n_checks++;
    if (viol !== 0 || ndel !== 0) begin n_fail++;
      $display("FAIL %s_hold got viol=%0d del=%0d want 0 0", nm, viol, ndel); end
  endtask

  task automatic test_del();
    pkt_q_t got;
    int ndel, lat, done, viol;
    xfer(mktok(3'd1, 8'h02, 7'd2, 1'b0, 1'b1, 32'h1234_5678), 0, 0,
         got, ndel, lat, done, viol);
    n_checks++;
    if (ndel !== 1) begin n_fail++;
      $display("FAIL del_pulse got %0d want 1", ndel); end
    n_checks++;
    if (got.size() !== 0 || lat !== -1) begin n_fail++;
      $display("FAIL del_no_out got n=%0d lat=%0d want 0 -1", got.size(), lat); end
  endtask

  task automatic test_cpy();
    ent_t e;
    pkt_q_t got, exp;
    int ndel, edel, lat, done, viol;
    logic [IN_W-1:0] tok;
    e = '{v:1, nd:10, lr:0, br:1, mf:0, cpy:1, opc:6'h21, nd2:11, lr2:1};
    wr_entry(3, e);
    tok = mktok(3'd5, 8'hC3, 7'd3, 1'b0, 1'b0, 32'hDEAD_BEEF);
    model(tok, exp, edel);
    xfer(tok, 40, 0, got, ndel, lat, done, viol);
    n_checks++;
    if (got.size() !== 2) begin n_fail++;
      $display("FAIL cpy_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got.size() != 2 || got[i] !== exp[i]) begin n_fail++;
        $display("FAIL cpy_pkt%0d got %h want %h", i,
                 got.size() > i ? got[i] : '0, exp[i]); end
    end
    n_checks++;
    if (viol !== 0) begin n_fail++;
      $display("FAIL cpy_hold got %0d want 0", viol); end
  endtask

  task automatic test_write_priority();
    ent_t e;
    pkt_q_t got, exp;
    int ndel, edel, lat, done, viol;
    logic [IN_W-1:0] tok;
    e = '{v:1, nd:7'h7F, lr:1, br:0, mf:1, cpy:0, opc:6'h3F, nd2:0, lr2:0};
    tok = mktok(3'd7, 8'hFF, 7'd127, 1'b1, 1'b1, 32'h0BAD_F00D);
    bus.in_valid   = 1'b1;
    bus.PACKET_IN  = tok;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 7'd127;
    bus.prog_wdata = {e.v, e.nd, e.lr, e.br, e.mf, e.cpy, e.opc, e.nd2, e.lr2};
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL wr_prio_in_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    bus.prog_we = 1'b0;
    prog[127] = e;
    model(tok, exp, edel);
    xfer(tok, 0, 0, got, ndel, lat, done, viol);
    n_checks++;
    if (got.size() !== 1 || got[0] !== exp[0] || ndel !== 0) begin n_fail++;
      $display("FAIL wr_prio_pkt got n=%0d %h want %h", got.size(),
               got.size() ? got[0] : '0, exp[0]); end
  endtask

  task automatic test_random();
    pkt_q_t got, exp;
    int ndel, edel, lat, done, viol;
    logic [IN_W-1:0] tok;
    ent_t e;
    for (int k = 0; k < 40; k++) begin
      e.v = ($urandom_range(3) != 0);
      e.nd = 7'($urandom); e.lr = 1'($urandom); e.br = 1'($urandom);
      e.mf = 1'($urandom); e.cpy = 1'($urandom); e.opc = 6'($urandom);
      e.nd2 = 7'($urandom); e.lr2 = 1'($urandom);
      wr_entry(7'($urandom_range(120, 127)), e);
    end
    for (int k = 0; k < 40; k++) begin
      tok = mktok(3'($urandom), 8'($urandom), 7'($urandom_range(120, 127)),
                  1'($urandom), 1'($urandom), 32'($urandom));
      model(tok, exp, edel);
      xfer(tok, $urandom_range(60), 0, got, ndel, lat, done, viol);
      n_checks++;
      if (got.size() !== exp.size() || ndel !== edel || viol !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_shape got n=%0d del=%0d viol=%0d want n=%0d del=%0d",
                 k, got.size(), ndel, viol, exp.size(), edel);
      end else begin
        foreach (exp[i]) begin
          n_checks++;
          if (got[i] !== exp[i]) begin n_fail++;
            $display("FAIL rnd%0d_pkt%0d got %h want %h", k, i, got[i], exp[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pkt_q_t got;
    int ndel, lat, done, viol;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.PACKET_IN = mktok(3'd1, 8'h01, 7'd3, 1'b0, 1'b0, 32'h5555_AAAA);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (!(bus.out_valid === 1'b1 && bus.PACKET_OUT[DATA_W+2+OPC_W+4 +: DEST_W] === 7'd11)) begin
      n_fail++;
      $display("FAIL mid_in_out2 got v=%b pkt=%h want v=1 dest=0b", bus.out_valid, bus.PACKET_OUT);
    end
    mr_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.DEL !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset got v=%b del=%b want 0 0", bus.out_valid, bus.DEL); end
    mr_n = 1'b1;
    bus.out_ready = 1'b1;
    clear_model();
    @(negedge clk);
    xfer(mktok(3'd1, 8'h01, 7'd3, 1'b0, 1'b0, 32'h5555_AAAA), 0, 0,
         got, ndel, lat, done, viol);
    n_checks++;
    if (ndel !== 1 || got.size() !== 0) begin n_fail++;
      $display("FAIL mid_resend got del=%0d n=%0d want 1 0", ndel, got.size()); end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.PACKET_IN  = '0;
    bus.out_ready  = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    for (int i = 0; i < 2**DEST_W; i++) prog[i] = '{default: 0};
    @(negedge clk);
    test_reset();
    test_single(0, "basic");
    test_del();
    test_cpy();
    test_single(5, "stall");
    test_write_priority();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
